dcache_assoc: RTL and testbench

//  Per-core, parametrised N-way set-associative data cache: next generation of the core data cache.

---
 rtl/dcache_assoc_if.sv | 48 ++++
 rtl/dcache_assoc.sv | 240 ++++++++++++++++++++++++
 tb/tb_dcache_assoc.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_assoc_if.sv
// Bundles the LSU, invalidate, memory-controller and statistics signals of dcache_assoc.
// The cache sits on the slave side; the LSU/memory environment uses the master side.
interface dcache_assoc_if #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8
);
   logic                 lsu_read_request;
   logic [ADDR_BITS-1:0] lsu_read_address;
   logic                 lsu_read_valid;
   logic [DATA_BITS-1:0] lsu_read_data;
   logic                 lsu_write_request;
   logic [ADDR_BITS-1:0] lsu_write_address;
   logic [DATA_BITS-1:0] lsu_write_data;
   logic                 lsu_write_valid;
   logic                 invalidate_request;
   logic                 invalidate_done;
   logic                 mem_read_valid;
   logic [ADDR_BITS-1:0] mem_read_address;
   logic                 mem_read_ready;
   logic [DATA_BITS-1:0] mem_read_data;
   logic                 mem_write_valid;
   logic [ADDR_BITS-1:0] mem_write_address;
   logic [DATA_BITS-1:0] mem_write_data;
   logic                 mem_write_ready;
   logic [31:0]          stat_read_hits;
   logic [31:0]          stat_read_misses;
   logic [31:0]          stat_write_hits;
   logic [31:0]          stat_write_requests;
   logic [31:0]          stat_mem_wait_cycles;

   modport slave (
      input  lsu_read_request, lsu_read_address, lsu_write_request, lsu_write_address,
             lsu_write_data, invalidate_request, mem_read_ready, mem_read_data, mem_write_ready,
      output lsu_read_valid, lsu_read_data, lsu_write_valid, invalidate_done,
             mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
             stat_read_hits, stat_read_misses, stat_write_hits, stat_write_requests,
             stat_mem_wait_cycles
   );

   modport master (
      output lsu_read_request, lsu_read_address, lsu_write_request, lsu_write_address,
             lsu_write_data, invalidate_request, mem_read_ready, mem_read_data, mem_write_ready,
      input  lsu_read_valid, lsu_read_data, lsu_write_valid, invalidate_done,
             mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
             stat_read_hits, stat_read_misses, stat_write_hits, stat_write_requests,
             stat_mem_wait_cycles
   );
endinterface

// File: rtl/dcache_assoc.sv
// N-way set-associative, write-through data cache with single-word lines, true-LRU ages,
// optional write-allocate, bulk invalidate and saturating statistics. All outputs are registered.
module dcache_assoc #(
   parameter int DATA_MEM_ADDR_BITS = 8,
   parameter int DATA_MEM_DATA_BITS = 8,
   parameter int CACHE_SIZE         = 32,
   parameter int WAYS               = 4,
   parameter int WRITE_ALLOCATE     = 0
) (
   input logic           clk,
   input logic           reset,
   dcache_assoc_if.slave bus
);
   localparam int A        = DATA_MEM_ADDR_BITS;
   localparam int D        = DATA_MEM_DATA_BITS;
   localparam int SETS     = CACHE_SIZE / WAYS;
   localparam int IB       = $clog2(SETS);
   localparam int TAG_BITS = A - IB;
   localparam int AB       = $clog2(WAYS);

   typedef enum logic [2:0] {IDLE, RD_MEM, WR_MEM, RESP, INV_DONE} state_t;

   state_t              state, state_next;
   logic                resp_read, resp_read_next;
   logic [WAYS-1:0]     valid_q [SETS];
   logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
   logic [D-1:0]        data_q  [SETS][WAYS];
   logic [AB-1:0]       age_q   [SETS][WAYS];

   logic [A-1:0]        op_addr;
   logic [IB-1:0]       op_index;
   logic [TAG_BITS-1:0] op_tag;
   logic                hit;
   logic [AB-1:0]       hit_way, victim_way, way_sel;
   logic                line_write, line_install, touch, inval_all;
   logic [D-1:0]        line_value;
   logic                read_valid_n, write_valid_n, inv_done_n, rd_valid_n, wr_valid_n;
   logic [A-1:0]        rd_addr_n, wr_addr_n;
   logic [D-1:0]        rd_data_n, wr_data_n;
   logic                inc_rhit, inc_rmiss, inc_whit, inc_wreq, inc_wait;
   logic                pulse_busy;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // In IDLE the lookup follows the highest-priority LSU request; during a fill it follows the miss address.
   always_comb begin
      op_addr = bus.mem_read_address;
      if (state == IDLE)
         op_addr = bus.lsu_write_request ? bus.lsu_write_address : bus.lsu_read_address;
   end

   assign op_index   = op_addr[IB-1:0];
   assign op_tag     = op_addr[A-1:IB];
   assign pulse_busy = bus.lsu_read_valid | bus.lsu_write_valid | bus.invalidate_done;

   // Victim is the lowest invalid way, otherwise the oldest way of the set.
   always_comb begin
      logic found;
      hit        = 1'b0;
      hit_way    = '0;
      victim_way = '0;
      found      = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[op_index][w] && tag_q[op_index][w] == op_tag) begin
            hit     = 1'b1;
            hit_way = AB'(w);
         end
         if (!valid_q[op_index][w] && !found) begin
            victim_way = AB'(w);
            found      = 1'b1;
         end
      end
      if (!found)
         for (int w = 0; w < WAYS; w++)
            if (age_q[op_index][w] == AB'(WAYS - 1)) victim_way = AB'(w);
   end

   // Next-state, registered-output and array-update controls. Pulses default low; held outputs keep their value.
   always_comb begin
      state_next    = state;
      resp_read_next = resp_read;
      read_valid_n  = 1'b0;
      write_valid_n = 1'b0;
      inv_done_n    = 1'b0;
      rd_valid_n    = bus.mem_read_valid;
      rd_addr_n     = bus.mem_read_address;
      rd_data_n     = bus.lsu_read_data;
      wr_valid_n    = bus.mem_write_valid;
      wr_addr_n     = bus.mem_write_address;
      wr_data_n     = bus.mem_write_data;
      line_write    = 1'b0;
      line_install  = 1'b0;
      touch         = 1'b0;
      inval_all     = 1'b0;
      way_sel       = hit_way;
      line_value    = bus.lsu_write_data;
      inc_rhit      = 1'b0;
      inc_rmiss     = 1'b0;
      inc_whit      = 1'b0;
      inc_wreq      = 1'b0;
      inc_wait      = 1'b0;
      case (state)
         IDLE: begin
            if (!pulse_busy) begin
               if (bus.invalidate_request) begin
                  inval_all  = 1'b1;
                  state_next = INV_DONE;
               end else if (bus.lsu_write_request) begin
                  inc_wreq       = 1'b1;
                  wr_valid_n     = 1'b1;
                  wr_addr_n      = bus.lsu_write_address;
                  wr_data_n      = bus.lsu_write_data;
                  resp_read_next = 1'b0;
                  state_next     = WR_MEM;
                  if (hit) begin
                     line_write = 1'b1;
                     touch      = 1'b1;
                     inc_whit   = 1'b1;
                  end else if (WRITE_ALLOCATE != 0) begin
                     line_write   = 1'b1;
                     line_install = 1'b1;
                     touch        = 1'b1;
                     way_sel      = victim_way;
                  end
               end else if (bus.lsu_read_request) begin
                  resp_read_next = 1'b1;
                  if (hit) begin
                     rd_data_n  = data_q[op_index][hit_way];
                     touch      = 1'b1;
                     inc_rhit   = 1'b1;
                     state_next = RESP;
                  end else begin
                     inc_rmiss  = 1'b1;
                     rd_valid_n = 1'b1;
                     rd_addr_n  = bus.lsu_read_address;
                     state_next = RD_MEM;
                  end
               end
            end
         end
         RD_MEM: begin
            if (bus.mem_read_ready) begin
               line_write   = 1'b1;
               line_install = 1'b1;
               touch        = 1'b1;
               way_sel      = victim_way;
               line_value   = bus.mem_read_data;
               rd_data_n    = bus.mem_read_data;
               rd_valid_n   = 1'b0;
               state_next   = RESP;
            end else begin
               inc_wait = 1'b1;
            end
         end
         WR_MEM: begin
            if (bus.mem_write_ready) begin
               wr_valid_n = 1'b0;
               state_next = RESP;
            end else begin
               inc_wait = 1'b1;
            end
         end
         RESP: begin
            read_valid_n  = resp_read;
            write_valid_n = !resp_read;
            state_next    = IDLE;
         end
         INV_DONE: begin
            inv_done_n = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register, registered outputs and saturating statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         state                    <= IDLE;
         resp_read                <= 1'b0;
         bus.lsu_read_valid       <= 1'b0;
         bus.lsu_read_data        <= '0;
         bus.lsu_write_valid      <= 1'b0;
         bus.invalidate_done      <= 1'b0;
         bus.mem_read_valid       <= 1'b0;
         bus.mem_read_address     <= '0;
         bus.mem_write_valid      <= 1'b0;
         bus.mem_write_address    <= '0;
         bus.mem_write_data       <= '0;
         bus.stat_read_hits       <= '0;
         bus.stat_read_misses     <= '0;
         bus.stat_write_hits      <= '0;
         bus.stat_write_requests  <= '0;
         bus.stat_mem_wait_cycles <= '0;
      end else begin
         state                 <= state_next;
         resp_read             <= resp_read_next;
         bus.lsu_read_valid    <= read_valid_n;
         bus.lsu_read_data     <= rd_data_n;
         bus.lsu_write_valid   <= write_valid_n;
         bus.invalidate_done   <= inv_done_n;
         bus.mem_read_valid    <= rd_valid_n;
         bus.mem_read_address  <= rd_addr_n;
         bus.mem_write_valid   <= wr_valid_n;
         bus.mem_write_address <= wr_addr_n;
         bus.mem_write_data    <= wr_data_n;
         if (inc_rhit)  bus.stat_read_hits       <= sat_inc(bus.stat_read_hits);
         if (inc_rmiss) bus.stat_read_misses     <= sat_inc(bus.stat_read_misses);
         if (inc_whit)  bus.stat_write_hits      <= sat_inc(bus.stat_write_hits);
         if (inc_wreq)  bus.stat_write_requests  <= sat_inc(bus.stat_write_requests);
         if (inc_wait)  bus.stat_mem_wait_cycles <= sat_inc(bus.stat_mem_wait_cycles);
      end
   end

   // Line storage and LRU ages; touching a way ages every younger way by one.
   always_ff @(posedge clk) begin
      if (reset || inval_all) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               age_q[s][w]   <= AB'(w);
            end
      end else begin
         if (line_write) data_q[op_index][way_sel] <= line_value;
         if (line_install) begin
            valid_q[op_index][way_sel] <= 1'b1;
            tag_q[op_index][way_sel]   <= op_tag;
         end
         if (touch)
            for (int w = 0; w < WAYS; w++) begin
               if (AB'(w) == way_sel)
                  age_q[op_index][w] <= '0;
               else if (age_q[op_index][w] < age_q[op_index][way_sel])
                  age_q[op_index][w] <= age_q[op_index][w] + AB'(1);
            end
      end
   end
endmodule

// File: tb/tb_dcache_assoc.sv
// Directed self-checking bench for dcache_assoc (WAYS=4, SETS=8, WRITE_ALLOCATE=0);
// a memory model answers every request after three not-ready cycles.
module tb_dcache_assoc;
   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   mem_reads  = 0;
   int   mem_writes = 0;
   logic [7:0] last_rd_addr, last_wr_addr, last_wr_data;

   dcache_assoc_if #(.ADDR_BITS(8), .DATA_BITS(8)) bif ();

   dcache_assoc #(
      .DATA_MEM_ADDR_BITS(8), .DATA_MEM_DATA_BITS(8), .CACHE_SIZE(32), .WAYS(4), .WRITE_ALLOCATE(0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: contents default to addr ^ 8'hC3, with 0x13 preset to 0xA5.
   initial begin
      logic [7:0] mem_model [256];
      int cnt;
      for (int i = 0; i < 256; i++) mem_model[i] = 8'(i) ^ 8'hC3;
      mem_model[8'h13] = 8'hA5;
      cnt = 0;
      bif.mem_read_ready  = 1'b0;
      bif.mem_write_ready = 1'b0;
      bif.mem_read_data   = '0;
      forever begin
         @(negedge clk);
         if (reset || !(bif.mem_read_valid || bif.mem_write_valid) ||
             bif.mem_read_ready || bif.mem_write_ready) begin
            cnt = 0;
            bif.mem_read_ready  = 1'b0;
            bif.mem_write_ready = 1'b0;
         end else if (cnt == 3) begin
            if (bif.mem_read_valid) begin
               bif.mem_read_ready = 1'b1;
               bif.mem_read_data  = mem_model[bif.mem_read_address];
               last_rd_addr       = bif.mem_read_address;
               mem_reads++;
            end else begin
               bif.mem_write_ready = 1'b1;
               mem_model[bif.mem_write_address] = bif.mem_write_data;
               last_wr_addr = bif.mem_write_address;
               last_wr_data = bif.mem_write_data;
               mem_writes++;
            end
         end else begin
            cnt++;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // One LSU transaction; lat counts negedges from raising the request to seeing the valid pulse.
   task automatic applyStimulus(input bit is_write, input logic [7:0] addr, input logic [7:0] wdata,
                                output logic [7:0] rdata, output int lat);
      bit done;
      @(negedge clk);
      if (is_write) begin
         bif.lsu_write_address = addr;
         bif.lsu_write_data    = wdata;
         bif.lsu_write_request = 1'b1;
      end else begin
         bif.lsu_read_address = addr;
         bif.lsu_read_request = 1'b1;
      end
      lat   = 0;
      rdata = '0;
      done  = 1'b0;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
         if (is_write ? bif.lsu_write_valid : bif.lsu_read_valid) begin
            done  = 1'b1;
            rdata = bif.lsu_read_data;
         end
      end
      bif.lsu_write_request = 1'b0;
      bif.lsu_read_request  = 1'b0;
      checkOutput("txn_completed", 32'(done), 32'd1);
   endtask

   task automatic runConcurrent(input bit with_inv, input logic [7:0] waddr, input logic [7:0] wdata,
                                input logic [7:0] raddr, output int inv_at, output int wr_at,
                                output int rd_at, output logic [7:0] rdata);
      @(negedge clk);
      inv_at = -1; wr_at = -1; rd_at = -1; rdata = '0;
      bif.invalidate_request = with_inv;
      bif.lsu_write_address  = waddr;
      bif.lsu_write_data     = wdata;
      bif.lsu_write_request  = 1'b1;
      bif.lsu_read_address   = raddr;
      bif.lsu_read_request   = 1'b1;
      for (int step = 1; step <= 200 && rd_at < 0; step++) begin
         @(negedge clk);
         if (bif.invalidate_done && inv_at < 0) begin inv_at = step; bif.invalidate_request = 1'b0; end
         if (bif.lsu_write_valid && wr_at < 0) begin wr_at = step; bif.lsu_write_request = 1'b0; end
         if (bif.lsu_read_valid && rd_at < 0) begin
            rd_at = step;
            rdata = bif.lsu_read_data;
            bif.lsu_read_request = 1'b0;
         end
      end
      bif.invalidate_request = 1'b0;
      bif.lsu_write_request  = 1'b0;
      bif.lsu_read_request   = 1'b0;
      checkOutput("concurrent_completed", 32'(rd_at > 0), 32'd1);
   endtask

   initial begin
      logic [7:0] rd;
      int lat, base, inv_at, wr_at, rd_at;
      bit seen;
      reset = 1'b1;
      bif.lsu_read_request = 1'b0;  bif.lsu_read_address  = '0;
      bif.lsu_write_request = 1'b0; bif.lsu_write_address = '0; bif.lsu_write_data = '0;
      bif.invalidate_request = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_read_valid", 32'(bif.lsu_read_valid), 32'd0);
      checkOutput("rst_read_data", 32'(bif.lsu_read_data), 32'd0);
      checkOutput("rst_mem_read_valid", 32'(bif.mem_read_valid), 32'd0);
      checkOutput("rst_mem_write_valid", 32'(bif.mem_write_valid), 32'd0);
      checkOutput("rst_stat_read_hits", bif.stat_read_hits, 32'd0);
      reset = 1'b0;

      $display("[TB] cold read miss and re-read hit");
      applyStimulus(0, 8'h13, 8'h00, rd, lat);
      checkOutput("t1_miss_data", 32'(rd), 32'hA5);
      checkOutput("t1_miss_latency", 32'(lat), 32'd6);
      checkOutput("t1_mem_reads", 32'(mem_reads), 32'd1);
      checkOutput("t1_mem_addr", 32'(last_rd_addr), 32'h13);
      checkOutput("t1_read_misses", bif.stat_read_misses, 32'd1);
      checkOutput("t1_wait_cycles", bif.stat_mem_wait_cycles, 32'd3);
      applyStimulus(0, 8'h13, 8'h00, rd, lat);
      checkOutput("t1_hit_data", 32'(rd), 32'hA5);
      checkOutput("t1_hit_latency", 32'(lat), 32'd2);
      checkOutput("t1_hit_no_mem", 32'(mem_reads), 32'd1);
      checkOutput("t1_read_hits", bif.stat_read_hits, 32'd1);

      $display("[TB] write hit then write miss without allocate");
      applyStimulus(1, 8'h13, 8'h5A, rd, lat);
      checkOutput("t3_mem_writes", 32'(mem_writes), 32'd1);
      checkOutput("t3_mem_wr_addr", 32'(last_wr_addr), 32'h13);
      checkOutput("t3_mem_wr_data", 32'(last_wr_data), 32'h5A);
      checkOutput("t3_write_hits", bif.stat_write_hits, 32'd1);
      applyStimulus(0, 8'h13, 8'h00, rd, lat);
      checkOutput("t3_read_after_write", 32'(rd), 32'h5A);
      checkOutput("t3_read_hit_latency", 32'(lat), 32'd2);
      applyStimulus(1, 8'h40, 8'h77, rd, lat);
      applyStimulus(0, 8'h40, 8'h00, rd, lat);
      checkOutput("t4_no_allocate_miss", 32'(mem_reads), 32'd2);
      checkOutput("t4_data_from_mem", 32'(rd), 32'h77);

      $display("[TB] LRU eviction within set 3");
      applyStimulus(0, 8'h03, 8'h00, rd, lat);
      checkOutput("t2_rd03", 32'(rd), 32'hC0);
      applyStimulus(0, 8'h0B, 8'h00, rd, lat);
      applyStimulus(0, 8'h13, 8'h00, rd, lat);
      checkOutput("t2_rd13_hit", 32'(lat), 32'd2);
      applyStimulus(0, 8'h1B, 8'h00, rd, lat);
      checkOutput("t2_rd1B", 32'(rd), 32'hD8);
      applyStimulus(0, 8'h03, 8'h00, rd, lat);
      applyStimulus(0, 8'h23, 8'h00, rd, lat);
      checkOutput("t2_rd23", 32'(rd), 32'hE0);
      base = mem_reads;
      applyStimulus(0, 8'h0B, 8'h00, rd, lat);
      checkOutput("t2_0B_evicted", 32'(mem_reads - base), 32'd1);
      checkOutput("t2_0B_data", 32'(rd), 32'hC8);
      applyStimulus(0, 8'h03, 8'h00, rd, lat);
      checkOutput("t2_03_still_hit", 32'(lat), 32'd2);
      checkOutput("t2_03_data", 32'(rd), 32'hC0);
      checkOutput("sum_read_hits", bif.stat_read_hits, 32'd5);
      checkOutput("sum_read_misses", bif.stat_read_misses, 32'd7);
      checkOutput("sum_write_hits", bif.stat_write_hits, 32'd1);
      checkOutput("sum_write_requests", bif.stat_write_requests, 32'd2);
      checkOutput("sum_wait_cycles", bif.stat_mem_wait_cycles, 32'd27);

      $display("[TB] request priority");
      runConcurrent(0, 8'h03, 8'h99, 8'h0B, inv_at, wr_at, rd_at, rd);
      checkOutput("t5_write_first", 32'(wr_at > 0 && wr_at < rd_at), 32'd1);
      checkOutput("t5_read_hit_data", 32'(rd), 32'hC8);
      checkOutput("t5_mem_reads", 32'(mem_reads), 32'd7);
      runConcurrent(1, 8'h0B, 8'h11, 8'h03, inv_at, wr_at, rd_at, rd);
      checkOutput("t5_inv_first", 32'(inv_at > 0 && inv_at < wr_at && wr_at < rd_at), 32'd1);
      checkOutput("t5_read_after_inv", 32'(rd), 32'h99);
      checkOutput("t5_inv_read_missed", 32'(mem_reads), 32'd8);

      $display("[TB] invalidate then reads miss");
      @(negedge clk);
      bif.invalidate_request = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = bif.invalidate_done;
      end
      bif.invalidate_request = 1'b0;
      checkOutput("t6_inv_done", 32'(seen), 32'd1);
      applyStimulus(0, 8'h1B, 8'h00, rd, lat);
      checkOutput("t6_1B_miss", 32'(mem_reads), 32'd9);
      checkOutput("t6_1B_data", 32'(rd), 32'hD8);
      applyStimulus(0, 8'h0B, 8'h00, rd, lat);
      checkOutput("t6_0B_data", 32'(rd), 32'h11);

      $display("[TB] reset during memory read");
      @(negedge clk);
      bif.lsu_read_address = 8'h55;
      bif.lsu_read_request = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = bif.mem_read_valid;
      end
      checkOutput("t6_rd_mem_entered", 32'(seen), 32'd1);
      reset = 1'b1;
      bif.lsu_read_request = 1'b0;
      @(negedge clk);
      checkOutput("t6_rst_mem_read_valid", 32'(bif.mem_read_valid), 32'd0);
      checkOutput("t6_rst_stat_misses", bif.stat_read_misses, 32'd0);
      reset = 1'b0;
      applyStimulus(0, 8'h55, 8'h00, rd, lat);
      checkOutput("t6_post_rst_data", 32'(rd), 32'h96);
      checkOutput("t6_post_rst_latency", 32'(lat), 32'd6);
      checkOutput("t6_post_rst_mem_reads", 32'(mem_reads), 32'd11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
